rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry, 64-bit, single-write-port register file. Several producers (ALU, load unit, mul/div) compete for the one write port. A round-robin arbiter grants one per cycle and drives a registered write to the register file. A per-register busy scoreboard lets the issue stage check read-port hazards against the three read addresses.

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- SIZE, 32, register count
- ADDR_WIDTH, $clog2(SIZE), register address width
- REG_WIDTH, 64, register data width
- DROP_X0, 1, when 1, writes and allocations to register 0 are discarded

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  requester i has a result
- req_ready  out  NREQ  grant; transfer on req_valid[i] & req_ready[i]
- req_addr  in  NREQ x ADDR_WIDTH  destination register per requester
- req_val  in  NREQ x REG_WIDTH  result data per requester
- wr_enable  out  1  register-file write enable (registered)
- wr_addr  out  ADDR_WIDTH  register-file write address (registered)
- wr_val  out  REG_WIDTH  register-file write data (registered)
- alloc_valid  in  1  issue stage marks a destination as pending
- alloc_addr  in  ADDR_WIDTH  register being allocated
- rd_addr  in  3 x ADDR_WIDTH  read-port addresses being issued
- rd_busy  out  3  busy[rd_addr[j]], combinational from registered state
- busy  out  SIZE  scoreboard vector

## Operation
- Arbitration:
  - Round-robin pointer `ptr` (0..NREQ-1).
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
  - The first i with req_valid[i] gets req_ready[i]=1; all other ready bits are 0.
  - req_ready is combinational from req_valid and ptr.
  - At most one ready bit is high. None is high if no requester is valid or rst_n=0.
  - After a grant to i, ptr becomes (i+1) mod NREQ. With no grant, ptr holds.
- Output stage:
  - On a grant, wr_enable<=1 and wr_addr/wr_val<=req_addr[i]/req_val[i].
  - With no grant, wr_enable<=0 and wr_addr/wr_val hold their values.
  - With DROP_X0=1 and req_addr[i]==0, the grant still happens and ptr still advances, but wr_enable<=0.
- Scoreboard:
  - set = alloc_valid, applied to bit alloc_addr.
  - clr = wr_enable (registered output high this cycle), applied to bit wr_addr.
  - On the edge: busy[a] <= set for a, else busy[a] & ~clr for a.
  - If set and clr target the same register in the same cycle, set wins (new producer).
  - alloc to an already busy register (WAW) leaves the bit at 1. The first write-back clears it, so the issue stage must stall WAW.
  - DROP_X0=1: alloc to 0 is ignored; busy[0] is constant 0.
- rd_busy[j] = busy[rd_addr[j]]. There is no bypass from the pending write.

## Timing
- Reset (rst_n=0 at posedge):
  - wr_enable=0, wr_addr=0, wr_val=0.
  - busy=all 0, ptr=0 (requester 0 highest priority).
  - req_ready=0 throughout reset.
  - A reset mid-stream drops the in-flight registered write (wr_enable=0 next cycle) and clears all pending bits.
- Write latency:
  - Handshake in cycle N puts wr_enable=1 in cycle N+1.
  - The register file captures at the end of N+1; data is readable from N+2.
- Busy-clear latency:
  - busy falls in cycle N+2, aligned with data visibility in the register file.
  - A read issued in cycle N+1 still sees rd_busy=1.
- Alloc latency: alloc in cycle M gives busy=1 from cycle M+1.
- Throughput:
  - One write per cycle, sustained.
  - A requester holding valid while others are valid waits at most NREQ-1 cycles.
- Requester rules:
  - req_valid must not depend on req_ready.
  - Once asserted, req_valid, req_addr and req_val are held until the handshake.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, then release with no valid requests -> wr_enable=0, busy=0, req_ready=0 every cycle.
- Single write: alloc x5 in cycle 0; req0 valid with addr 5, val 0xDEAD_BEEF_0000_0001 in cycle 2 -> ready0=1 in cycle 2; wr_enable=1, wr_addr=5, wr_val=0xDEAD_BEEF_0000_0001 in cycle 3; busy[5]=1 in cycles 1-3 and 0 from cycle 4; rd_busy for rd_addr=5 follows the same timing.
- Round-robin fairness: all 3 requesters valid continuously with addrs 1/2/3 -> grant order 0,1,2,0,1,2; wr_addr sequence 1,2,3,1,2,3 with one write per cycle.
- Same-register set and clear: wr_enable=1 with wr_addr=7 and alloc_addr=7 in the same cycle -> busy[7] stays 1.
- x0 discard: req1 writes addr 0 with val 0xFF, and an alloc to 0 is issued -> ready1=1 and ptr advances to 2; wr_enable=0 next cycle; busy[0]=0.
- Reset mid-operation: rst_n=0 in the cycle where wr_enable=1 and busy=0x0000_00A0 -> next cycle wr_enable=0, busy=0, ptr=0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between result producers / issue stage (master) and the
// register-file write-back arbiter with its busy scoreboard (slave).
interface rf_wb_arbiter_if #(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned SIZE       = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
   parameter int unsigned REG_WIDTH  = 64
);
   logic [NREQ-1:0]                 req_valid;
   logic [NREQ-1:0]                 req_ready;
   logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [NREQ-1:0][REG_WIDTH-1:0]  req_val;

   logic                            wr_enable;
   logic [ADDR_WIDTH-1:0]           wr_addr;
   logic [REG_WIDTH-1:0]            wr_val;

   logic                            alloc_valid;
   logic [ADDR_WIDTH-1:0]           alloc_addr;
   logic [2:0][ADDR_WIDTH-1:0]      rd_addr;
   logic [2:0]                      rd_busy;
   logic [SIZE-1:0]                 busy;

   modport master (
      output req_valid, req_addr, req_val, alloc_valid, alloc_addr, rd_addr,
      input  req_ready, wr_enable, wr_addr, wr_val, rd_busy, busy
   );

   modport slave (
      input  req_valid, req_addr, req_val, alloc_valid, alloc_addr, rd_addr,
      output req_ready, wr_enable, wr_addr, wr_val, rd_busy, busy
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter driving a registered register-file write port,
// plus a per-register busy scoreboard for read-hazard checks at issue.
module rf_wb_arbiter #(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned SIZE       = 32,
   parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
   parameter int unsigned REG_WIDTH  = 64,
   parameter bit          DROP_X0    = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   rf_wb_arbiter_if.slave  bus
);
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  grant_valid;
   logic [PTR_W-1:0]      grant_idx;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic [REG_WIDTH-1:0]  grant_val;
   logic                  grant_drop;

   logic                  wr_enable_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [REG_WIDTH-1:0]  wr_val_q;
   logic [SIZE-1:0]       busy_q, busy_d;

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      int unsigned      cand;
      logic [PTR_W-1:0] cand_idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         cand     = (32'(ptr_q) + 32'(k)) % NREQ;
         cand_idx = PTR_W'(cand);
         if (!grant_valid && bus.req_valid[cand_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (rst_n && grant_valid) begin
         bus.req_ready[grant_idx] = 1'b1;
      end
   end

   assign grant_addr = bus.req_addr[grant_idx];
   assign grant_val  = bus.req_val[grant_idx];
   assign grant_drop = DROP_X0 && (grant_addr == '0);

   always_comb begin
      ptr_d = ptr_q;
      if (grant_valid) begin
         ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Set beats clear so a new producer on the register being retired stays pending.
   always_comb begin
      busy_d = busy_q;
      if (wr_enable_q && (32'(wr_addr_q) < SIZE)) begin
         busy_d[wr_addr_q] = 1'b0;
      end
      if (bus.alloc_valid && (32'(bus.alloc_addr) < SIZE)) begin
         busy_d[bus.alloc_addr] = 1'b1;
      end
      if (DROP_X0) begin
         busy_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         wr_enable_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_val_q    <= '0;
         busy_q      <= '0;
      end else begin
         ptr_q  <= ptr_d;
         busy_q <= busy_d;
         if (grant_valid) begin
            wr_enable_q <= !grant_drop;
            wr_addr_q   <= grant_addr;
            wr_val_q    <= grant_val;
         end else begin
            wr_enable_q <= 1'b0;
         end
      end
   end

   assign bus.wr_enable = wr_enable_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_val    = wr_val_q;
   assign bus.busy      = busy_q;

   // No bypass: a write in flight still reads as busy.
   always_comb begin
      bus.rd_busy = '0;
      for (int j = 0; j < 3; j++) begin
         if (32'(bus.rd_addr[j]) < SIZE) begin
            bus.rd_busy[j] = busy_q[bus.rd_addr[j]];
         end
      end
   end

   assert property (@(posedge clk) $onehot0(bus.req_ready));
   assert property (@(posedge clk) !DROP_X0 || !busy_q[0]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, round-robin order,
// same-register set/clear, x0 discard and reset mid-stream.
module tb_rf_wb_arbiter;
   localparam int unsigned NREQ = 3;
   localparam int unsigned SIZE = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned RW   = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   rf_wb_arbiter_if #(.NREQ(NREQ), .SIZE(SIZE), .ADDR_WIDTH(AW), .REG_WIDTH(RW)) bus ();

   rf_wb_arbiter #(
      .NREQ(NREQ), .SIZE(SIZE), .ADDR_WIDTH(AW), .REG_WIDTH(RW), .DROP_X0(1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.req_valid   = 3'b111;
      bus.req_addr    = '0;
      bus.req_val     = '0;
      bus.alloc_valid = 1'b0;
      bus.alloc_addr  = '0;
      bus.rd_addr     = '0;

      // Reset with requesters valid: nothing may be granted.
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_wen", 64'(bus.wr_enable), 64'd0);
         check("rst_busy", 64'(bus.busy), 64'd0);
         check("rst_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = '0;
      rst_n         = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         check("idle_wen", 64'(bus.wr_enable), 64'd0);
         check("idle_busy", 64'(bus.busy), 64'd0);
         check("idle_ready", 64'(bus.req_ready), 64'd0);
      end

      // Single write: alloc x5 in cycle 0, handshake in cycle 2.
      bus.alloc_valid = 1'b1;
      bus.alloc_addr  = 5'd5;
      bus.rd_addr[0]  = 5'd5;
      bus.rd_addr[1]  = 5'd4;
      bus.rd_addr[2]  = 5'd5;
      #1;
      check("sw_c0_busy", 64'(bus.busy), 64'd0);
      tick();
      bus.alloc_valid = 1'b0;
      #1;
      check("sw_c1_busy", 64'(bus.busy), 64'h20);
      check("sw_c1_rdbusy", 64'(bus.rd_busy), 64'b101);
      tick();
      bus.req_valid   = 3'b001;
      bus.req_addr[0] = 5'd5;
      bus.req_val[0]  = 64'hDEAD_BEEF_0000_0001;
      #1;
      check("sw_c2_ready", 64'(bus.req_ready), 64'b001);
      check("sw_c2_busy", 64'(bus.busy), 64'h20);
      tick();
      bus.req_valid = '0;
      #1;
      check("sw_c3_wen", 64'(bus.wr_enable), 64'd1);
      check("sw_c3_waddr", 64'(bus.wr_addr), 64'd5);
      check("sw_c3_wval", bus.wr_val, 64'hDEAD_BEEF_0000_0001);
      check("sw_c3_busy", 64'(bus.busy), 64'h20);
      check("sw_c3_rdbusy", 64'(bus.rd_busy), 64'b101);
      tick();
      check("sw_c4_wen", 64'(bus.wr_enable), 64'd0);
      check("sw_c4_busy", 64'(bus.busy), 64'd0);
      check("sw_c4_rdbusy", 64'(bus.rd_busy), 64'd0);

      // Re-reset so the pointer starts at requester 0 for the fairness run.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.req_addr[0] = 5'd1;
      bus.req_addr[1] = 5'd2;
      bus.req_addr[2] = 5'd3;
      bus.req_val[0]  = 64'h100;
      bus.req_val[1]  = 64'h101;
      bus.req_val[2]  = 64'h102;
      for (int k = 0; k <= 6; k++) begin
         bus.req_valid = (k < 6) ? 3'b111 : 3'b000;
         #1;
         if (k < 6) begin
            check($sformatf("rr_ready%0d", k), 64'(bus.req_ready), 64'(3'b001 << (k % 3)));
         end
         if (k > 0) begin
            check($sformatf("rr_wen%0d", k), 64'(bus.wr_enable), 64'd1);
            check($sformatf("rr_waddr%0d", k), 64'(bus.wr_addr), 64'((k - 1) % 3 + 1));
            check($sformatf("rr_wval%0d", k), bus.wr_val, 64'(256 + (k - 1) % 3));
         end
         tick();
      end

      // Same-register set and clear: alloc x7 while its write-back retires.
      bus.req_valid   = '0;
      bus.alloc_valid = 1'b1;
      bus.alloc_addr  = 5'd7;
      tick();
      bus.alloc_valid = 1'b0;
      bus.req_valid   = 3'b001;
      bus.req_addr[0] = 5'd7;
      bus.req_val[0]  = 64'h77;
      #1;
      check("sr_ready", 64'(bus.req_ready), 64'b001);
      check("sr_busy_pre", 64'(bus.busy), 64'h80);
      tick();
      bus.req_valid   = '0;
      bus.alloc_valid = 1'b1;
      bus.alloc_addr  = 5'd7;
      #1;
      check("sr_wen", 64'(bus.wr_enable), 64'd1);
      check("sr_waddr", 64'(bus.wr_addr), 64'd7);
      tick();
      bus.alloc_valid = 1'b0;
      #1;
      check("sr_busy_set_wins", 64'(bus.busy), 64'h80);
      check("sr_wen_off", 64'(bus.wr_enable), 64'd0);
      tick();
      check("sr_busy_hold", 64'(bus.busy), 64'h80);

      // x0 discard: pointer is at 1, req1 targets register 0, alloc to 0 too.
      bus.req_valid   = 3'b010;
      bus.req_addr[1] = 5'd0;
      bus.req_val[1]  = 64'hFF;
      bus.alloc_valid = 1'b1;
      bus.alloc_addr  = 5'd0;
      #1;
      check("x0_ready", 64'(bus.req_ready), 64'b010);
      tick();
      bus.alloc_valid = 1'b0;
      bus.req_valid   = 3'b111;
      #1;
      check("x0_wen", 64'(bus.wr_enable), 64'd0);
      check("x0_busy", 64'(bus.busy), 64'h80);
      check("x0_ptr_adv", 64'(bus.req_ready), 64'b100);
      tick();
      bus.req_valid = '0;
      #1;
      check("x0_next_wen", 64'(bus.wr_enable), 64'd1);
      check("x0_next_waddr", 64'(bus.wr_addr), 64'd3);
      check("x0_next_wval", bus.wr_val, 64'h102);

      // Reset mid-stream: write in flight and busy=0xA0 when reset hits.
      bus.alloc_valid = 1'b1;
      bus.alloc_addr  = 5'd5;
      bus.req_valid   = 3'b001;
      bus.req_addr[0] = 5'd3;
      bus.req_val[0]  = 64'h33;
      #1;
      check("mr_ready", 64'(bus.req_ready), 64'b001);
      tick();
      bus.alloc_valid = 1'b0;
      bus.req_valid   = 3'b111;
      #1;
      check("mr_wen_pre", 64'(bus.wr_enable), 64'd1);
      check("mr_busy_pre", 64'(bus.busy), 64'hA0);
      rst_n = 1'b0;
      #1;
      check("mr_ready_in_rst", 64'(bus.req_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("mr_wen", 64'(bus.wr_enable), 64'd0);
      check("mr_busy", 64'(bus.busy), 64'd0);
      check("mr_waddr", 64'(bus.wr_addr), 64'd0);
      check("mr_wval", bus.wr_val, 64'd0);
      check("mr_ptr0", 64'(bus.req_ready), 64'b001);
      tick();
      bus.req_valid = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
